// File: rtl/kernel_conv_filter.sv
// KxK signed-kernel convolution on one pixel window per cycle: products, adder tree,
// then round/shift/clamp, as a three-stage pipeline that stalls as a whole on backpressure.
module kernel_conv_filter #(
    parameter int PIX_W  = 8,
    parameter int K      = 3,
    parameter int COEF_W = 8
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic [K*K*PIX_W-1:0]    window_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              shift_cfg,
    input  logic                    coef_wr_en,
    input  logic [4:0]              coef_wr_addr,
    input  logic [COEF_W-1:0]       coef_wr_data,
    output logic [PIX_W-1:0]        pix_out,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int N      = K * K;
    localparam int PROD_W = PIX_W + 1 + COEF_W;
    localparam int SUM_W  = PROD_W + $clog2(N);
    localparam int RND_W  = SUM_W + 1;
    localparam logic signed [RND_W-1:0] PIX_MAX = {{(RND_W-PIX_W){1'b0}}, {PIX_W{1'b1}}};

    // Gaussian smoothing kernel for 3x3, scaled identity (centre 16) for 5x5.
    function automatic logic signed [COEF_W-1:0] coef_reset_val(input int idx);
        logic signed [COEF_W-1:0] v;
        if (K == 3) begin
            case (idx)
                4:          v = COEF_W'(32'sd4);
                1, 3, 5, 7: v = COEF_W'(32'sd2);
                0, 2, 6, 8: v = COEF_W'(32'sd1);
                default:    v = COEF_W'(32'sd0);
            endcase
        end else begin
            v = (idx == N / 2) ? COEF_W'(32'sd16) : COEF_W'(32'sd0);
        end
        return v;
    endfunction

    logic signed [COEF_W-1:0] coef_r [N];
    logic signed [PROD_W-1:0] prod_s [N];
    logic signed [PROD_W-1:0] prod_r [N];
    logic signed [SUM_W-1:0]  sum_s;
    logic signed [SUM_W-1:0]  sum_r;
    logic signed [RND_W-1:0]  rnd_add_s;
    logic signed [RND_W-1:0]  rnd_s;
    logic signed [RND_W-1:0]  shifted_s;
    logic [PIX_W-1:0]         clamp_s;
    logic [3:0]               shift1_r;
    logic [3:0]               shift2_r;
    logic                     v1_r;
    logic                     v2_r;
    logic                     en_s;

    assign en_s     = !out_valid || out_ready;
    assign in_ready = en_s;

    // Coefficient file: writes land regardless of stall; out-of-range addresses match no entry.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rstN) begin
                coef_r[i] <= coef_reset_val(i);
            end else if (coef_wr_en && (coef_wr_addr == 5'(i))) begin
                coef_r[i] <= $signed(coef_wr_data);
            end
        end
    end

    // Per-tap products, pixel zero-extended so it is always non-negative.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            prod_s[i] = PROD_W'($signed({1'b0, window_in[i*PIX_W +: PIX_W]})) * PROD_W'(coef_r[i]);
        end
    end

    // Adder tree over the registered products.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < N; i++) begin
            sum_s = sum_s + SUM_W'(prod_r[i]);
        end
    end

    // Round half-up, arithmetic shift, clamp to the unsigned pixel range.
    always_comb begin
        if (shift2_r != 4'd0) begin
            rnd_add_s = {{(RND_W-1){1'b0}}, 1'b1} << (shift2_r - 4'd1);
        end else begin
            rnd_add_s = '0;
        end
        rnd_s     = RND_W'(sum_r) + rnd_add_s;
        shifted_s = rnd_s >>> shift2_r;
        if (shifted_s[RND_W-1]) begin
            clamp_s = '0;
        end else if (shifted_s > PIX_MAX) begin
            clamp_s = {PIX_W{1'b1}};
        end else begin
            clamp_s = shifted_s[PIX_W-1:0];
        end
    end

    // Pipeline registers; all three stages advance or hold together.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            for (int i = 0; i < N; i++) begin
                prod_r[i] <= '0;
            end
            v1_r      <= 1'b0;
            shift1_r  <= 4'd0;
            v2_r      <= 1'b0;
            sum_r     <= '0;
            shift2_r  <= 4'd0;
            out_valid <= 1'b0;
            pix_out   <= '0;
        end else if (en_s) begin
            prod_r    <= prod_s;
            v1_r      <= in_valid;
            shift1_r  <= shift_cfg;
            v2_r      <= v1_r;
            sum_r     <= sum_s;
            shift2_r  <= shift1_r;
            out_valid <= v2_r;
            pix_out   <= clamp_s;
        end
    end

endmodule

// File: tb/tb_kernel_conv_filter.sv
// Directed bench for kernel_conv_filter (K=3): vector table plus stall, coefficient-timing
// and mid-stream reset sequences.
module tb_kernel_conv_filter;

    localparam int PIX_W = 8;
    localparam int K = 3;
    localparam int COEF_W = 8;
    localparam int N = K * K;

    logic                 clk = 1'b0;
    logic                 rstN;
    logic [N*PIX_W-1:0]   window_in;
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           shift_cfg;
    logic                 coef_wr_en;
    logic [4:0]           coef_wr_addr;
    logic [COEF_W-1:0]    coef_wr_data;
    logic [PIX_W-1:0]     pix_out;
    logic                 out_valid;
    logic                 out_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int kid;
        int all;
        int ctr;
        int sh;
        int exp;
    } vec_t;

    kernel_conv_filter #(.PIX_W(PIX_W), .K(K), .COEF_W(COEF_W)) dut (
        .clk(clk), .rstN(rstN), .window_in(window_in), .in_valid(in_valid),
        .in_ready(in_ready), .shift_cfg(shift_cfg), .coef_wr_en(coef_wr_en),
        .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data), .pix_out(pix_out),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [N*PIX_W-1:0] mk_win(input int all, input int ctr);
        logic [N*PIX_W-1:0] w;
        for (int i = 0; i < N; i++) begin
            w[i*PIX_W +: PIX_W] = (i == 4) ? 8'(ctr) : 8'(all);
        end
        return w;
    endfunction

    task automatic wr_coef(input int addr, input int data);
        @(negedge clk);
        coef_wr_en = 1'b1;
        coef_wr_addr = 5'(addr);
        coef_wr_data = 8'(data);
        @(negedge clk);
        coef_wr_en = 1'b0;
    endtask

    // 0 gaussian, 1 identity, 2 all 127, 3 centre -16
    task automatic load_kernel(input int id);
        int g [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        for (int i = 0; i < N; i++) begin
            case (id)
                0: wr_coef(i, g[i]);
                1: wr_coef(i, (i == 4) ? 1 : 0);
                2: wr_coef(i, 127);
                default: wr_coef(i, (i == 4) ? -16 : 0);
            endcase
        end
    endtask

    task automatic run_one(input logic [N*PIX_W-1:0] win, input int sh, output int pix, output int lat);
        @(negedge clk);
        window_in = win;
        shift_cfg = 4'(sh);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        pix = int'(pix_out);
        @(negedge clk);
    endtask

    initial begin
        vec_t tv [13];
        int pix, lat, cur_k, idx, stall_cnt, cnt;
        int got [$];

        tv[0]  = '{0, 100, 100, 4, 100};
        tv[1]  = '{0,   0, 255, 4,  64};
        tv[2]  = '{0, 255, 255, 0, 255};
        tv[3]  = '{0,  10,  10, 2,  40};
        tv[4]  = '{1,   0,   3, 1,   2};
        tv[5]  = '{1,   0,   4, 1,   2};
        tv[6]  = '{1,   0,   5, 1,   3};
        tv[7]  = '{1,   0, 200, 0, 200};
        tv[8]  = '{1,   0, 255, 0, 255};
        tv[9]  = '{2, 255, 255, 0, 255};
        tv[10] = '{2,   1,   1, 4,  71};
        tv[11] = '{3,   0, 200, 0,   0};
        tv[12] = '{3,   0,   0, 15,  0};

        rstN = 1'b0;
        in_valid = 1'b0;
        window_in = '0;
        shift_cfg = 4'd0;
        coef_wr_en = 1'b0;
        coef_wr_addr = 5'd0;
        coef_wr_data = 8'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        check("reset out_valid", int'(out_valid), 0);
        check("reset pix_out", int'(pix_out), 0);
        check("reset in_ready", int'(in_ready), 1);

        // Table: reset kernel first, then reloaded kernels
        cur_k = 0;
        for (int i = 0; i < 13; i++) begin
            if (tv[i].kid != cur_k) begin
                load_kernel(tv[i].kid);
                cur_k = tv[i].kid;
            end
            run_one(mk_win(tv[i].all, tv[i].ctr), tv[i].sh, pix, lat);
            check($sformatf("vec%0d pix", i), pix, tv[i].exp);
            check($sformatf("vec%0d latency", i), lat, 3);
        end

        // Stream of 10 windows with a 5-cycle downstream stall
        load_kernel(1);
        idx = 0;
        stall_cnt = 0;
        got.delete();
        for (int c = 0; c < 60 && got.size() < 10; c++) begin
            @(negedge clk);
            out_ready = !(c >= 6 && c < 11);
            in_valid = (idx < 10);
            window_in = mk_win(0, idx + 1);
            shift_cfg = 4'd0;
            #1;
            if (!out_ready && out_valid) begin
                stall_cnt++;
                check("stall in_ready", int'(in_ready), 0);
            end
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) got.push_back(int'(pix_out));
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream stall cycles", stall_cnt, 5);
        check("stream count", got.size(), 10);
        for (int i = 0; i < got.size(); i++) begin
            check($sformatf("stream out%0d", i), got[i], i + 1);
        end

        // Coefficient write in the accept cycle: old kernel for that window, new for the next
        @(negedge clk);
        window_in = mk_win(0, 50);
        shift_cfg = 4'd0;
        in_valid = 1'b1;
        coef_wr_en = 1'b1;
        coef_wr_addr = 5'd4;
        coef_wr_data = 8'd2;
        @(negedge clk);
        coef_wr_en = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        got.delete();
        for (int c = 0; c < 10 && got.size() < 2; c++) begin
            @(negedge clk);
            if (out_valid) got.push_back(int'(pix_out));
        end
        check("coef swap count", got.size(), 2);
        if (got.size() == 2) begin
            check("coef swap old", got[0], 50);
            check("coef swap new", got[1], 100);
        end
        wr_coef(9, 100);
        run_one(mk_win(10, 10), 0, pix, lat);
        check("addr9 ignored", pix, 20);

        // Reset with three windows in flight
        load_kernel(1);
        @(negedge clk);
        window_in = mk_win(100, 100);
        shift_cfg = 4'd4;
        in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        in_valid = 1'b0;
        check("midreset out_valid", int'(out_valid), 0);
        check("midreset in_ready", int'(in_ready), 1);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("midreset stale outputs", cnt, 0);
        run_one(mk_win(100, 100), 4, pix, lat);
        check("midreset gaussian restored", pix, 100);
        check("midreset latency", lat, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kernel_conv_filter.md
KERNEL_CONV_FILTER -- requirements
Module: kernel_conv_filter

Interface
REQ-001 SHALL have parameter PIX_W, default 8, meaning the unsigned pixel width.
REQ-002 SHALL have parameter K, default 3, meaning the kernel side; only 3 or 5 are legal.
REQ-003 SHALL have parameter COEF_W, default 8, meaning the signed two's-complement coefficient width.
REQ-004 SHALL have port clk, input, 1 bit, the clock.
REQ-005 SHALL have port rstN, input, 1 bit, a synchronous active-low reset.
REQ-006 SHALL have port window_in, input, K*K*PIX_W bits, the pixel window; pixel i is window_in[i*PIX_W +: PIX_W], row-major, i=0 top-left.
REQ-007 SHALL have port in_valid, input, 1 bit, meaning window_in is valid.
REQ-008 SHALL have port in_ready, output, 1 bit, meaning the block accepts a window this cycle.
REQ-009 SHALL have port shift_cfg, input, 4 bits, the normalisation right-shift; it is sampled with the window.
REQ-010 SHALL have port coef_wr_en, input, 1 bit, the coefficient write strobe.
REQ-011 SHALL have port coef_wr_addr, input, 5 bits, the coefficient index, row-major.
REQ-012 SHALL have port coef_wr_data, input, COEF_W bits, the signed coefficient value.
REQ-013 SHALL have port pix_out, output, PIX_W bits, the filtered pixel.
REQ-014 SHALL have port out_valid, output, 1 bit, meaning pix_out is valid.
REQ-015 SHALL have port out_ready, input, 1 bit, meaning downstream accepts pix_out.

Function
REQ-016 SHALL form a 3-stage pipeline: S1 registers the K*K products coef[i]*pixel[i] with shift_cfg; S2 registers the signed adder-tree sum; S3 registers the rounded, shifted, clamped pixel.
REQ-017 SHALL transfer a window when in_valid && in_ready, and an output when out_valid && out_ready.
REQ-018 SHALL advance all stages together on en = !out_valid || out_ready; in_ready = en; when en=0, every stage register and valid bit holds.
REQ-019 SHALL give a latency of exactly 3 cycles from accept to out_valid when there is no stall; throughput is 1 window/cycle.
REQ-020 SHALL keep valid bits per stage, so bubbles propagate and are never emitted as outputs.
REQ-021 SHALL size products as signed PIX_W+1+COEF_W bits, with the pixel zero-extended.
REQ-022 SHALL size the sum as product width + ceil(log2(K*K)) bits, with no internal overflow possible.
REQ-023 SHALL round S3 as: if shift_cfg>0, add 1<<(shift_cfg-1); then arithmetic right shift by shift_cfg.
REQ-024 SHALL clamp S3 as: negative results give 0; results > 2^PIX_W-1 give 2^PIX_W-1.
REQ-025 SHALL hold a coefficient register file of K*K entries; a write takes effect the cycle after coef_wr_en.
REQ-026 SHALL compute a window accepted in the same cycle as a coefficient write with the old coefficients.
REQ-027 SHALL apply coefficient writes regardless of stall state; windows already past S1 are unaffected.
REQ-028 SHALL ignore a write with coef_wr_addr >= K*K and leave all coefficients unchanged.
REQ-029 SHALL not let a mid-stream change of shift_cfg affect windows already accepted.

Reset
REQ-030 SHALL, when rstN=0 at a clk edge, clear all stage registers, valid bits, pix_out and out_valid to 0.
REQ-031 SHALL drive in_ready=1 in the first cycle after reset.
REQ-032 SHALL reset the coefficients to the Gaussian 1 2 1 / 2 4 2 / 1 2 1 when K=3.
REQ-033 SHALL reset the coefficients to centre=16 and all others 0 when K=5.
REQ-034 SHALL discard in-flight data on reset mid-operation, with no partial output afterwards.

Verification
REQ-035 SHALL cover: K=3 reset coefficients, all pixels 100, shift_cfg=4, out_ready=1 -> pix_out=100 with out_valid exactly 3 cycles after accept.
REQ-036 SHALL cover: write coef[4]=1 and all others 0, shift_cfg=1, centre pixel 3 -> pix_out=2; centre pixel 4 -> pix_out=2.
REQ-037 SHALL cover: coef all 127, pixels all 255, shift_cfg=0 -> pix_out=255; coef[4]=-16 and others 0, centre 200 -> pix_out=0.
REQ-038 SHALL cover: a stream of 10 windows (values 1..10, identity kernel) with out_ready low for 5 cycles mid-stream -> in_ready low while stalled, all 10 outputs in order, none lost or duplicated.
REQ-039 SHALL cover: a coef write in the same cycle as an accepted window -> that window uses the old kernel and the next window uses the new one; a write to addr 9 (K=3) -> no change.
REQ-040 SHALL cover: rstN low for 1 cycle with 3 windows in flight -> out_valid=0 next cycle, no stale output, coefficients back to reset values.
